// File: rtl/alu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared funct codes, result-mux encodings, FSM states and funct classifier
// for the ALU control sequencer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_ctrl_pkg;

  // R-type funct codes
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;

  // Result mux select (2'b11 reserved)
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_SHT  = 2'b01;
  localparam logic [1:0] WB_HILO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_SHT  = 2'd1,
    CLS_MDU  = 2'd2,
    CLS_HILO = 2'd3
  } fclass_t;

  // Unknown funct codes fall through to the ALU class.
  function automatic fclass_t classify(input logic [5:0] f);
    case (f)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: return CLS_ALU;
      FN_SLL, FN_SRL:                        return CLS_SHT;
      FN_MULTU, FN_DIVU:                     return CLS_MDU;
      FN_MFHI, FN_MFLO:                      return CLS_HILO;
      default:                               return CLS_ALU;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_cycle_counter.sv
// ----------------------------------------------------------------------------
// mdu_cycle_counter
// Loadable down-counter timing an MDU operation; saturates at zero.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mdu_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Clear beats load beats decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/alu_control_seq.sv
// ----------------------------------------------------------------------------
// alu_control_seq
// Decodes R-type funct codes to ALU/shifter/MDU/HiLo controls and sequences
// multi-cycle MDU operations with a handshake, flush and HiLo write pulse.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [5:0] funct_i,
  input  logic       flush_i,
  output logic       ready_o,
  output logic [5:0] alu_op_o,
  output logic [5:0] sht_op_o,
  output logic [5:0] mdu_op_o,
  output logic [5:0] hilo_op_o,
  output logic [1:0] wb_sel_o,
  output logic       mdu_start_o,
  output logic       hilo_we_o,
  output logic       busy_o,
  output logic       done_o
);

  // Counter preloads are N-1 so WB lands N+1 cycles after acceptance.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t           state, state_n;
  logic [5:0]       alu_n, sht_n, mdu_n, hilo_n;
  logic [1:0]       wb_n;
  logic             start_n, we_n, busy_n, done_n, ready_n;
  logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_val;

  mdu_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  // Next-state and next-output decode; op outputs hold unless updated.
  always_comb begin
    state_n      = state;
    alu_n        = alu_op_o;
    sht_n        = sht_op_o;
    mdu_n        = mdu_op_o;
    hilo_n       = hilo_op_o;
    wb_n         = wb_sel_o;
    start_n      = 1'b0;
    we_n         = 1'b0;
    done_n       = 1'b0;
    busy_n       = busy_o;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;

    case (state)
      ST_IDLE: begin
        // Flush has no effect here; a valid instruction is still accepted.
        if (valid_i) begin
          case (classify(funct_i))
            CLS_SHT: begin
              sht_n = funct_i;
              wb_n  = WB_SHT;
            end
            CLS_HILO: begin
              hilo_n = funct_i;
              wb_n   = WB_HILO;
            end
            CLS_MDU: begin
              mdu_n        = funct_i;
              start_n      = 1'b1;
              busy_n       = 1'b1;
              cnt_load     = 1'b1;
              cnt_load_val = (funct_i == FN_DIVU) ? DIV_LOAD : MUL_LOAD;
              state_n      = ST_RUN;
            end
            default: begin
              alu_n = funct_i;
              wb_n  = WB_ALU;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          state_n = ST_WB;
          we_n    = 1'b1;
          done_n  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WB: begin
        // The write pulse is already visible; leave regardless of flush.
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        cnt_clr = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase

    ready_n = (state_n == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      alu_op_o    <= '0;
      sht_op_o    <= '0;
      mdu_op_o    <= '0;
      hilo_op_o   <= '0;
      wb_sel_o    <= WB_ALU;
      mdu_start_o <= 1'b0;
      hilo_we_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ready_o     <= 1'b1;
    end else begin
      state       <= state_n;
      alu_op_o    <= alu_n;
      sht_op_o    <= sht_n;
      mdu_op_o    <= mdu_n;
      hilo_op_o   <= hilo_n;
      wb_sel_o    <= wb_n;
      mdu_start_o <= start_n;
      hilo_we_o   <= we_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      ready_o     <= ready_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_control_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_control_seq
// Directed self-checking bench for alu_control_seq (DIV 32 cycles, MUL 4).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic [5:0] funct_i;
  logic       flush_i;
  logic       ready_o;
  logic [5:0] alu_op_o, sht_op_o, mdu_op_o, hilo_op_o;
  logic [1:0] wb_sel_o;
  logic       mdu_start_o, hilo_we_o, busy_o, done_o;

  int tests = 0;
  int fails = 0;

  // {mdu_start, busy, hilo_we, done, ready}
  logic [4:0] st;
  assign st = {mdu_start_o, busy_o, hilo_we_o, done_o, ready_o};

  alu_control_seq #(.DIV_CYCLES(32), .MUL_CYCLES(4), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .funct_i     (funct_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .alu_op_o    (alu_op_o),
    .sht_op_o    (sht_op_o),
    .mdu_op_o    (mdu_op_o),
    .hilo_op_o   (hilo_op_o),
    .wb_sel_o    (wb_sel_o),
    .mdu_start_o (mdu_start_o),
    .hilo_we_o   (hilo_we_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; funct_i = 6'd0; flush_i = 1'b0;
    tick(); tick();
    tests++;
    if (st !== 5'b00001) begin
      fails++; $display("FAIL reset_status got=%b exp=%b", st, 5'b00001);
    end
    tests++;
    if ({alu_op_o, sht_op_o, mdu_op_o, hilo_op_o, wb_sel_o} !== 26'd0) begin
      fails++; $display("FAIL reset_ops got alu=%0d sht=%0d mdu=%0d hilo=%0d wb=%0d exp all 0",
                        alu_op_o, sht_op_o, mdu_op_o, hilo_op_o, wb_sel_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_cycle();
    valid_i = 1'b1; funct_i = 6'd32; tick();
    tests++;
    if ({alu_op_o, wb_sel_o, st} !== {6'd32, 2'b00, 5'b00001}) begin
      fails++; $display("FAIL add got alu=%0d wb=%0d st=%b exp alu=32 wb=0 st=00001", alu_op_o, wb_sel_o, st);
    end
    funct_i = 6'd2; tick();
    tests++;
    if ({sht_op_o, wb_sel_o, alu_op_o, st} !== {6'd2, 2'b01, 6'd32, 5'b00001}) begin
      fails++; $display("FAIL srl got sht=%0d wb=%0d alu=%0d st=%b exp sht=2 wb=1 alu=32 st=00001",
                        sht_op_o, wb_sel_o, alu_op_o, st);
    end
    funct_i = 6'd16; tick();
    tests++;
    if ({hilo_op_o, wb_sel_o, st} !== {6'd16, 2'b10, 5'b00001}) begin
      fails++; $display("FAIL mfhi got hilo=%0d wb=%0d st=%b exp hilo=16 wb=2 st=00001", hilo_op_o, wb_sel_o, st);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_divu();
    logic [4:0] exp;
    valid_i = 1'b1; funct_i = 6'd27; tick(); valid_i = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      exp = {c == 1, c <= 33, c == 33, c == 33, c >= 34};
      tests++;
      if (st !== exp) begin
        fails++; $display("FAIL divu_cycle%0d got=%b exp=%b", c, st, exp);
      end
      tick();
    end
    tests++;
    if ({mdu_op_o, wb_sel_o} !== {6'd27, 2'b10}) begin
      fails++; $display("FAIL divu_ops got mdu=%0d wb=%0d exp mdu=27 wb=2", mdu_op_o, wb_sel_o);
    end
  endtask

  task automatic test_mul_stall();
    logic [4:0] exp;
    logic [5:0] exp_alu;
    valid_i = 1'b1; funct_i = 6'd36; tick();
    funct_i = 6'd25; tick();
    funct_i = 6'd32;  // ADD held while busy
    for (int c = 1; c <= 8; c++) begin
      exp     = {c == 1, c <= 5, c == 5, c == 5, c >= 6};
      exp_alu = (c >= 7) ? 6'd32 : 6'd36;
      tests++;
      if ({st, alu_op_o, mdu_op_o} !== {exp, exp_alu, 6'd25}) begin
        fails++; $display("FAIL mul_stall_cycle%0d got st=%b alu=%0d mdu=%0d exp st=%b alu=%0d mdu=25",
                          c, st, alu_op_o, mdu_op_o, exp, exp_alu);
      end
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic test_flush();
    logic [4:0] exp;
    valid_i = 1'b1; funct_i = 6'd27; tick(); valid_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp = {c == 1, c <= 10, 1'b0, 1'b0, c >= 11};
      tests++;
      if (st !== exp) begin
        fails++; $display("FAIL flush_run_cycle%0d got=%b exp=%b", c, st, exp);
      end
      if (c == 10) flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
    end
    valid_i = 1'b1; funct_i = 6'd27; tick(); valid_i = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      exp = {c == 1, c <= 33, c == 33, c == 33, c >= 34};
      tests++;
      if (st !== exp) begin
        fails++; $display("FAIL restart_cycle%0d got=%b exp=%b", c, st, exp);
      end
      tick();
    end
    // Flush in IDLE must not block acceptance
    flush_i = 1'b1; valid_i = 1'b1; funct_i = 6'd0; tick();
    flush_i = 1'b0; valid_i = 1'b0;
    tests++;
    if ({sht_op_o, wb_sel_o, ready_o} !== {6'd0, 2'b01, 1'b1}) begin
      fails++; $display("FAIL flush_idle got sht=%0d wb=%0d ready=%b exp sht=0 wb=1 ready=1",
                        sht_op_o, wb_sel_o, ready_o);
    end
  endtask

  task automatic test_flush_wb();
    valid_i = 1'b1; funct_i = 6'd25; tick(); valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    tests++;
    if (st !== 5'b01110) begin
      fails++; $display("FAIL flush_wb_pulse got=%b exp=%b", st, 5'b01110);
    end
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    for (int c = 6; c <= 8; c++) begin
      tests++;
      if (st !== 5'b00001) begin
        fails++; $display("FAIL flush_wb_after_cycle%0d got=%b exp=%b", c, st, 5'b00001);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    valid_i = 1'b1; funct_i = 6'd27; tick(); valid_i = 1'b0;
    for (int c = 1; c <= 14; c++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tests++;
    if ({alu_op_o, sht_op_o, mdu_op_o, hilo_op_o, wb_sel_o, st} !== {26'd0, 5'b00001}) begin
      fails++; $display("FAIL reset_mid got alu=%0d sht=%0d mdu=%0d hilo=%0d wb=%0d st=%b exp zeros st=00001",
                        alu_op_o, sht_op_o, mdu_op_o, hilo_op_o, wb_sel_o, st);
    end
    for (int c = 0; c < 36; c++) begin
      tests++;
      if (st !== 5'b00001) begin
        fails++; $display("FAIL reset_mid_after%0d got=%b exp=%b", c, st, 5'b00001);
      end
      tick();
    end
    valid_i = 1'b1; funct_i = 6'd63; tick(); valid_i = 1'b0;
    tests++;
    if ({alu_op_o, wb_sel_o, st} !== {6'd63, 2'b00, 5'b00001}) begin
      fails++; $display("FAIL unknown_funct got alu=%0d wb=%0d st=%b exp alu=63 wb=0 st=00001",
                        alu_op_o, wb_sel_o, st);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_divu();
    test_mul_stall();
    test_flush();
    test_flush_wb();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised successor to the single-issue ALU control decoder.
- Decodes the 6-bit R-type funct code and routes it to the ALU, shifter, multiply/divide unit (MDU) and HiLo register file.
- Sequences multi-cycle MDU operations (DIVU, MULTU) with a valid/ready handshake, a programmable cycle count, a flush input and a single HiLo write pulse.
- Sits between the main decoder and the datapath execute stage.

Parameters:
DIV_CYCLES, 32, cycles the divider needs from start to result valid (>=1)
MUL_CYCLES, 32, cycles the multiplier needs from start to result valid (>=1)
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(DIV_CYCLES, MUL_CYCLES)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
valid_i  in  1  funct_i holds a valid instruction this cycle
funct_i  in  6  R-type funct code
flush_i  in  1  cancel any in-flight MDU operation
ready_o  out  1  block can accept an instruction (state IDLE)
alu_op_o  out  6  funct forwarded to ALU
sht_op_o  out  6  funct forwarded to shifter
mdu_op_o  out  6  funct forwarded to MDU
hilo_op_o  out  6  funct forwarded to HiLo read mux
wb_sel_o  out  2  result mux: 00 ALU, 01 shifter, 10 HiLo, 11 reserved
mdu_start_o  out  1  one-cycle MDU start pulse
hilo_we_o  out  1  one-cycle HiLo write enable (MDU result capture)
busy_o  out  1  MDU operation in flight
done_o  out  1  MDU operation completed this cycle (same cycle as hilo_we_o)

Behaviour:
- All outputs are registered. Reset (rst_n=0 at a rising edge):
  - all op outputs 0, wb_sel_o=00;
  - mdu_start_o, hilo_we_o, busy_o, done_o = 0;
  - ready_o=1, state IDLE, counter 0.
- Funct classes:
  - ALU: AND 36, OR 37, ADD 32, SUB 34, SLT 42
  - SHT: SLL 0, SRL 2
  - MDU: MULTU 25, DIVU 27
  - HILO: MFHI 16, MFLO 18
  - Any other code is treated as ALU.
- An instruction is accepted on an edge where valid_i=1 and ready_o=1.
- States:
  - IDLE:
    - ALU/SHT/HILO accept: the matching op output and wb_sel_o (00/01/10) update at the edge; stay IDLE; single-cycle, back-to-back allowed.
    - MDU accept: mdu_op_o=funct_i, mdu_start_o=1 for the next cycle only, counter = (DIV_CYCLES or MUL_CYCLES)-1, busy_o=1, ready_o=0, go RUN.
  - RUN:
    - counter decrements each edge.
    - When counter==0 at an edge, go WB.
  - WB:
    - hilo_we_o=1 and done_o=1 for exactly this cycle; busy_o stays 1.
    - Next edge: IDLE, busy_o=0, ready_o=1.
- Latency: if an MDU op is accepted at edge 0, hilo_we_o is high in cycle N+1 and ready_o returns in cycle N+2 (N = configured cycles). DIVU default: hilo_we_o in cycle 33.
- Outputs not updated by an operation hold their last value. In particular, wb_sel_o is unchanged by MDU ops.
- valid_i while ready_o=0 is ignored; upstream must hold the instruction (stall).
- flush_i=1 in RUN or WB:
  - next edge goes to IDLE and clears busy_o, hilo_we_o, done_o, mdu_start_o;
  - no HiLo write occurs; flush beats a simultaneous WB.
- flush_i in IDLE has no effect, and any valid_i on that edge is still accepted.
- Reset mid-operation aborts with no hilo_we_o pulse.
- Reset dominates flush, which dominates everything else.

Decomposition:
- Shared package `alu_ctrl_pkg`:
  - funct localparams (AND, OR, ADD, SUB, SLT, SLL, SRL, MULTU, DIVU, MFHI, MFLO);
  - wb_sel encodings;
  - FSM state encoding IDLE/RUN/WB.
- One natural sub-module: `mdu_cycle_counter` (load, decrement, zero flag, CNT_W wide).
- The decoder stays inline.

Test Plan:
- ADD(32), SRL(2), MFHI(16) on consecutive cycles with valid_i=1 -> alu_op_o=32/wb_sel=00, then sht_op_o=2/wb_sel=01, then hilo_op_o=16/wb_sel=10; ready_o stays 1; no mdu_start_o.
- DIVU(27) accepted at edge 0, defaults -> mdu_start_o high cycle 1 only, busy_o high cycles 1-33, hilo_we_o=done_o=1 in cycle 33 only, ready_o=1 in cycle 34.
- MUL_CYCLES=4, MULTU(25), with valid_i=1/ADD held during busy -> ADD ignored until ready; hilo_we_o in cycle 5; ADD accepted at the first edge with ready_o=1.
- DIVU then flush_i=1 in cycle 10 -> busy_o=0 in cycle 11, no hilo_we_o ever; next DIVU restarts the full 32-cycle count.
- flush_i asserted exactly in the WB cycle -> hilo_we_o still visible that cycle (already registered), no second pulse; IDLE next.
- rst_n=0 in cycle 15 of DIVU -> all outputs reset values next cycle, ready_o=1, no hilo_we_o; unknown funct 63 afterwards -> alu_op_o=63, wb_sel=00.
